// File: rtl/fetch_queue.sv
// fetch_queue: converts the word-addressed PC stream into instruction-memory
// read requests and buffers the in-order responses for decode.
// Each FIFO slot is reserved when its request is accepted. The slot then
// fills when the matching response returns. A branch redirect flushes every
// slot and discards the responses that are still in flight.
// Optional build macro FETCH_BYPASS_EN: a response that targets the unfilled
// head slot is forwarded to decode in the same cycle it arrives.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  redirect,
  output logic                  fetch_stall,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Requests for the new path can issue while older reads are still being
  // dropped. Two extra bits give headroom for back-to-back redirects against
  // a slow memory.
  localparam int DROP_W = PTR_W + 3;

  // Slot storage.
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]      filled;

  // head_ptr: oldest reserved slot.
  // tail_ptr: next slot to reserve.
  // fill_ptr: oldest reserved slot that is still waiting for its response.
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [CNT_W-1:0]  count;     // reserved slots, 0..DEPTH
  logic [CNT_W-1:0]  out_cnt;   // live requests still awaiting a response
  logic [DROP_W-1:0] drop_cnt;  // in-flight responses to discard after a flush
  logic              active;    // low during reset and the first cycle after it

  logic              req_fire;
  logic              id_fire;
  logic              resp_accept;
  logic [DROP_W-1:0] drop_total;
  logic [DROP_W-1:0] drop_flush;

  // Hold request issue off until the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of statement or block order.
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  // Response acceptance, flush drop count, and the decode-side view of the head slot.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    resp_accept = imem_resp_valid && (drop_cnt == '0) && (out_cnt != '0) && !redirect;
    drop_total  = drop_cnt + DROP_W'(out_cnt);
    drop_flush  = drop_total;
    if (imem_resp_valid && (drop_total != '0)) drop_flush = drop_total - DROP_W'(1);
`ifdef FETCH_BYPASS_EN
    id_valid = filled[head_ptr];
    id_inst  = inst_mem[head_ptr];
    if (resp_accept && (count != '0) && (fill_ptr == head_ptr) && !filled[head_ptr]) begin
      id_valid = 1'b1;
      id_inst  = imem_resp_data;
    end
`else
    id_valid = filled[head_ptr];
    id_inst  = inst_mem[head_ptr];
`endif
    id_pc = pc_mem[head_ptr];
  end

  // Request handshake and the fetch-stage stall.
  always_comb begin
    id_fire        = id_valid && id_ready;
    imem_req_valid = active && !redirect && ((count < CNT_W'(DEPTH)) || id_fire);
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    fetch_stall    = !active || (!req_fire && !redirect);
  end

  // Slot contents. Later statements win when they touch the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the slot arrays are reset because they are only DEPTH entries
    // deep and id_inst/id_pc must read 0 straight out of reset. A deep
    // buffer would normally be left unreset.
    if (!rst_n) begin
      filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect) begin
      filled <= '0;
    end else begin
      if (resp_accept) begin
        inst_mem[fill_ptr] <= imem_resp_data;
        filled[fill_ptr]   <= 1'b1;
      end
      // A bypassed head is freed here even though the response filled it above.
      if (id_fire) filled[head_ptr] <= 1'b0;
      if (req_fire) begin
        pc_mem[tail_ptr] <= pc;
        filled[tail_ptr] <= 1'b0;
      end
    end
  end

  // Pointers, occupancy, and the outstanding and drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= drop_flush;
    end else begin
      if (id_fire)     head_ptr <= head_ptr + PTR_W'(1);
      if (req_fire)    tail_ptr <= tail_ptr + PTR_W'(1);
      if (resp_accept) fill_ptr <= fill_ptr + PTR_W'(1);
      count   <= count + CNT_W'(req_fire) - CNT_W'(id_fire);
      out_cnt <= out_cnt + CNT_W'(req_fire) - CNT_W'(resp_accept);
      if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - DROP_W'(1);
    end
  end

endmodule
